// File: rtl/risc_pkg.sv
// Shared definitions for the 5-stage processor: opcodes, instruction field
// positions and the scoreboard slot used by the interlock controller.
package risc_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_LSL  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_NOP  = 5'd13;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BGT  = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 27;
  localparam int IMM_BIT = 26;
  localparam int RD_HI   = 25;
  localparam int RD_LO   = 22;
  localparam int RS1_HI  = 21;
  localparam int RS1_LO  = 18;
  localparam int RS2_HI  = 17;
  localparam int RS2_LO  = 14;

  localparam int          REG_W    = 4;
  localparam logic [31:0] NOP_INST = 32'h6800_0000;
  localparam logic [REG_W-1:0] RA_REG = 4'd15;

  typedef struct packed {
    logic             valid;
    logic             wr_reg;
    logic [REG_W-1:0] rd;
    logic             wr_flag;
  } sb_slot_t;

  localparam sb_slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/hazard_decode.sv
// Combinational decode of the OF instruction into the registers/flags it
// reads and the register/flags it writes.
module hazard_decode
  import risc_pkg::*;
(
  input  logic [31:0]      of_inst,
  output logic             rd1_en,
  output logic [REG_W-1:0] rs1,
  output logic             rd2_en,
  output logic [REG_W-1:0] rs2,
  output logic             rd3_en,
  output logic [REG_W-1:0] rs3,
  output logic             rd_flag,
  output logic             wr_reg,
  output logic [REG_W-1:0] wr_dst,
  output logic             wr_flag
);

  logic [4:0] opc;
  logic       imm;

  assign opc = of_inst[OPC_HI:OPC_LO];
  assign imm = of_inst[IMM_BIT];

  always_comb begin
    rs1     = of_inst[RS1_HI:RS1_LO];
    rs2     = of_inst[RS2_HI:RS2_LO];
    rs3     = of_inst[RD_HI:RD_LO];
    wr_dst  = of_inst[RD_HI:RD_LO];
    rd1_en  = 1'b0;
    rd2_en  = !imm && (opc <= OP_ASR);
    rd3_en  = 1'b0;
    rd_flag = 1'b0;
    wr_reg  = 1'b0;
    wr_flag = 1'b0;
    case (opc)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR,
      OP_LSL, OP_LSR, OP_ASR, OP_LD: begin
        rd1_en = 1'b1;
        wr_reg = 1'b1;
      end
      OP_CMP: begin
        rd1_en  = 1'b1;
        wr_flag = 1'b1;
      end
      OP_NOT, OP_MOV: wr_reg = 1'b1;
      // st stores the rd register, so rd is a third source
      OP_ST: begin
        rd1_en = 1'b1;
        rd3_en = 1'b1;
      end
      OP_BEQ, OP_BGT: rd_flag = 1'b1;
      OP_CALL: begin
        wr_reg = 1'b1;
        wr_dst = RA_REG;
      end
      OP_RET: begin
        rd3_en = 1'b1;
        rs3    = RA_REG;
      end
      OP_NOP, OP_B: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock: scoreboard of writers in EX/MA/RW, RAW and flag hazard
// detection, branch flush, and saturating stall/flush event counters.
module hazard_ctrl
  import risc_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int DEPTH    = 3,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      of_inst,
  input  logic             of_valid,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int SRC_W = $clog2(NUM_REGS);

  logic             rd1_en, rd2_en, rd3_en, rd_flag;
  logic [REG_W-1:0] rs1, rs2, rs3, wr_dst;
  logic             wr_reg, wr_flag;

  hazard_decode u_decode (
    .of_inst (of_inst),
    .rd1_en  (rd1_en),
    .rs1     (rs1),
    .rd2_en  (rd2_en),
    .rs2     (rs2),
    .rd3_en  (rd3_en),
    .rs3     (rs3),
    .rd_flag (rd_flag),
    .wr_reg  (wr_reg),
    .wr_dst  (wr_dst),
    .wr_flag (wr_flag)
  );

  sb_slot_t         sb_q [DEPTH];
  sb_slot_t         sb_d [DEPTH];
  logic [DEPTH-1:0] hit;
  logic             hazard;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  // No forwarding: any slot still holding a matching writer blocks the reader.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign hit[gi] = sb_q[gi].valid &
      ((sb_q[gi].wr_reg &
        ((rd1_en & (sb_q[gi].rd[SRC_W-1:0] == rs1[SRC_W-1:0])) |
         (rd2_en & (sb_q[gi].rd[SRC_W-1:0] == rs2[SRC_W-1:0])) |
         (rd3_en & (sb_q[gi].rd[SRC_W-1:0] == rs3[SRC_W-1:0])))) |
       (sb_q[gi].wr_flag & rd_flag));
  end

  assign hazard = |hit;

  always_comb begin
    flush  = ex_branch_taken;
    stall  = hazard & of_valid & ~ex_branch_taken;
    bubble = stall | flush;
  end

  always_comb begin
    sb_d[0] = SLOT_EMPTY;
    if (of_valid && !stall && !flush) begin
      sb_d[0].valid   = 1'b1;
      sb_d[0].wr_reg  = wr_reg;
      sb_d[0].rd      = wr_dst;
      sb_d[0].wr_flag = wr_flag;
    end
    for (int i = 1; i < DEPTH; i++) begin
      sb_d[i] = sb_q[i-1];
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
    if (flush && (flush_count_q != '1)) flush_count_d = flush_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= SLOT_EMPTY;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= sb_d[i];
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, hand sequences for reset and
// padded code, then random stimulus against a timestamp-based register model.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] of_inst;
  logic        of_valid;
  logic        ex_branch_taken;
  logic        stall, bubble, flush;
  logic [31:0] stall_count, flush_count;

  hazard_ctrl #(.NUM_REGS(16), .DEPTH(3), .CNT_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .of_inst         (of_inst),
    .of_valid        (of_valid),
    .ex_branch_taken (ex_branch_taken),
    .stall           (stall),
    .bubble          (bubble),
    .flush           (flush),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_NOP   = 32'h6800_0000;
  localparam logic [31:0] I_MOV1  = 32'h4C40_0001;  // mov r1,1
  localparam logic [31:0] I_MOV0  = 32'h4C00_000A;  // mov r0,10
  localparam logic [31:0] I_ADD   = 32'h0084_4000;  // add r2,r1,r1
  localparam logic [31:0] I_MUL   = 32'h1044_8000;
  localparam logic [31:0] I_SUB   = 32'h0C88_0001;  // sub r2,r2,1
  localparam logic [31:0] I_CMP   = 32'h2C08_0001;  // cmp r2,1
  localparam logic [31:0] I_BGT   = 32'h8800_0005;
  localparam logic [31:0] I_CALL  = 32'h9800_0000;
  localparam logic [31:0] I_RET   = 32'hA000_0000;

  typedef struct {
    logic [31:0] inst;
    logic        valid;
    logic        ebt;
    logic        exp_stall;
    logic        exp_bubble;
    logic        exp_flush;
    int          exp_sc;
    int          exp_fc;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: per register/flag, the last cycle in which a writer is
  // still in EX/MA/RW; a reader in OF during that cycle or earlier must wait.
  int busy_until[16];
  int flag_until;
  int cyc = 0;
  int exp_sc, exp_fc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic [31:0] i, input logic v, input logic e,
                      input logic s, input logic b, input logic f, input int sc, input int fc);
    vec_t t;
    t.inst = i; t.valid = v; t.ebt = e; t.exp_stall = s; t.exp_bubble = b;
    t.exp_flush = f; t.exp_sc = sc; t.exp_fc = fc;
    vq.push_back(t);
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic e);
    of_inst = i; of_valid = v; ex_branch_taken = e;
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 16; r++) busy_until[r] = -100;
    flag_until = -100;
    exp_sc = 0;
    exp_fc = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0; of_valid = 1'b0; ex_branch_taken = 1'b0; of_inst = I_NOP;
    @(posedge clk); @(posedge clk); #1;
    cyc += 2;
    reset = 1'b1;
    model_clear();
  endtask

  function automatic bit reads_reg(input logic [31:0] inst, input int r);
    int op, rd, s1, s2;
    bit imm;
    op = int'(inst[31:27]); imm = inst[26];
    rd = int'(inst[25:22]); s1 = int'(inst[21:18]); s2 = int'(inst[17:14]);
    reads_reg = 1'b0;
    if ((op <= 7 || (op >= 10 && op <= 12) || op == 14 || op == 15) && s1 == r) reads_reg = 1'b1;
    if (!imm && op <= 12 && s2 == r) reads_reg = 1'b1;
    if (op == 15 && rd == r) reads_reg = 1'b1;
    if (op == 20 && r == 15) reads_reg = 1'b1;
  endfunction

  function automatic int dest_reg(input logic [31:0] inst);
    int op;
    op = int'(inst[31:27]);
    if (op <= 4 || (op >= 6 && op <= 12) || op == 14) return int'(inst[25:22]);
    if (op == 19) return 15;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] prog [$];
    int pool [4] = '{0, 1, 2, 15};

    reset = 1'b0; of_valid = 1'b0; ex_branch_taken = 1'b0; of_inst = I_ADD;

    // Reset held for two cycles
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_bubble", 32'(bubble), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_sc", stall_count, 0);
    chk("rst_fc", flush_count, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      drive(I_ADD, 1'b0, 1'b0);
      chk("idle_sc", stall_count, 0);
      chk("idle_stall", 32'(stall), 0);
      $display("idle %0d stall=%b sc=%0d", k, stall, stall_count);
      next_cycle();
    end

    // Directed table: RAW, flag, call/ret, flush-over-stall
    addv(I_MOV1, 1, 0, 0, 0, 0, 0, 0);
    addv(I_ADD,  1, 0, 1, 1, 0, 0, 0);
    addv(I_ADD,  1, 0, 1, 1, 0, 1, 0);
    addv(I_ADD,  1, 0, 1, 1, 0, 2, 0);
    addv(I_ADD,  1, 0, 0, 0, 0, 3, 0);
    for (int k = 0; k < 4; k++) addv(I_NOP, 1, 0, 0, 0, 0, 3, 0);
    addv(I_CMP,  1, 0, 0, 0, 0, 3, 0);
    addv(I_BGT,  1, 0, 1, 1, 0, 3, 0);
    addv(I_BGT,  1, 0, 1, 1, 0, 4, 0);
    addv(I_BGT,  1, 0, 1, 1, 0, 5, 0);
    addv(I_BGT,  1, 0, 0, 0, 0, 6, 0);
    addv(I_CALL, 1, 0, 0, 0, 0, 6, 0);
    addv(I_RET,  1, 0, 1, 1, 0, 6, 0);
    addv(I_RET,  1, 0, 1, 1, 0, 7, 0);
    addv(I_RET,  1, 0, 1, 1, 0, 8, 0);
    addv(I_RET,  1, 0, 0, 0, 0, 9, 0);
    addv(I_MOV1, 1, 0, 0, 0, 0, 9, 0);
    addv(I_ADD,  1, 1, 0, 1, 1, 9, 0);
    addv(I_SUB,  1, 0, 0, 0, 0, 9, 1);   // flushed add left no r2 writer
    addv(I_NOP,  1, 0, 0, 0, 0, 9, 1);

    foreach (vq[n]) begin
      drive(vq[n].inst, vq[n].valid, vq[n].ebt);
      chk($sformatf("vec%0d_stall", n), 32'(stall), 32'(vq[n].exp_stall));
      chk($sformatf("vec%0d_bubble", n), 32'(bubble), 32'(vq[n].exp_bubble));
      chk($sformatf("vec%0d_flush", n), 32'(flush), 32'(vq[n].exp_flush));
      chk($sformatf("vec%0d_sc", n), stall_count, 32'(vq[n].exp_sc));
      chk($sformatf("vec%0d_fc", n), flush_count, 32'(vq[n].exp_fc));
      $display("vec %0d inst=%h v=%b br=%b stall=%b bubble=%b flush=%b sc=%0d fc=%0d",
               n, vq[n].inst, vq[n].valid, vq[n].ebt, stall, bubble, flush, stall_count, flush_count);
      next_cycle();
    end

    // Asynchronous reset during the second stall cycle
    drive(I_MOV1, 1'b1, 1'b0);
    next_cycle();
    drive(I_ADD, 1'b1, 1'b0);
    chk("mid_stall1", 32'(stall), 1);
    next_cycle();
    drive(I_ADD, 1'b1, 1'b0);
    chk("mid_stall2", 32'(stall), 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_bubble", 32'(bubble), 0);
    chk("mid_rst_sc", stall_count, 0);
    chk("mid_rst_fc", flush_count, 0);
    $display("mid-stall reset stall=%b sc=%0d fc=%0d", stall, stall_count, flush_count);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", 32'(stall), 0);
    chk("post_rst_sc", stall_count, 0);
    chk("post_rst_fc", flush_count, 0);
    $display("post reset stall=%b sc=%0d", stall, stall_count);
    next_cycle();

    // Program already padded with independent nops: never stalls
    do_reset();
    prog = '{I_MOV0, I_MOV1, I_NOP, I_NOP, I_NOP, I_MUL, I_NOP, I_NOP, I_NOP,
             I_SUB, I_NOP, I_NOP, I_NOP, I_CMP, I_NOP, I_NOP, I_NOP, I_BGT};
    foreach (prog[n]) begin
      drive(prog[n], 1'b1, 1'b0);
      chk($sformatf("prog%0d_stall", n), 32'(stall), 0);
      $display("prog %0d inst=%h stall=%b", n, prog[n], stall);
      next_cycle();
    end
    @(negedge clk);
    chk("prog_sc", stall_count, 0);
    next_cycle();

    // Random stimulus against the register-timestamp model
    do_reset();
    for (int n = 0; n < 300; n++) begin
      logic [31:0] inst;
      logic v, e, es, ef, eb, haz;
      int d;
      inst = {5'($urandom_range(0, 23)), 1'($urandom_range(0, 1)),
              4'(pool[$urandom_range(0, 3)]), 4'(pool[$urandom_range(0, 3)]),
              4'(pool[$urandom_range(0, 3)]), 14'($urandom)};
      v = ($urandom_range(0, 9) != 0);
      e = ($urandom_range(0, 9) == 0);
      drive(inst, v, e);
      haz = 1'b0;
      if ((inst[31:27] == 5'd16 || inst[31:27] == 5'd17) && flag_until >= cyc) haz = 1'b1;
      for (int r = 0; r < 16; r++)
        if (reads_reg(inst, r) && busy_until[r] >= cyc) haz = 1'b1;
      ef = e;
      es = haz && v && !e;
      eb = es || ef;
      chk("rnd_stall", 32'(stall), 32'(es));
      chk("rnd_bubble", 32'(bubble), 32'(eb));
      chk("rnd_flush", 32'(flush), 32'(ef));
      chk("rnd_sc", stall_count, 32'(exp_sc));
      chk("rnd_fc", flush_count, 32'(exp_fc));
      $display("rnd %0d inst=%h v=%b br=%b stall=%b flush=%b sc=%0d", n, inst, v, e, stall, flush, stall_count);
      if (es) exp_sc++;
      if (ef) exp_fc++;
      if (v && !es && !ef) begin
        d = dest_reg(inst);
        if (d >= 0) busy_until[d] = cyc + 3;
        if (inst[31:27] == 5'd5) flag_until = cyc + 3;
      end
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
